uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Byte-level command sequencer between the uart block's RX/TX FIFO ports and one
//  memory request port (SDRAM controller user side). Pops command packets from the
//  RX FIFO, issues one single-word read or write, and pushes the response into the
//  TX FIFO. It is the host-debug path into memory.
// PARAMETERS
//  AddrWidth      24         memory word address width; AddrBytes = ceil(AddrWidth/8)
//  DataWidth      16         memory word width, multiple of 8; DataBytes = DataWidth/8
//  TimeoutCycles  1_000_000  max i_clk cycles between RX bytes inside a packet
// PORTS
//  i_clk          in   1          system clock
//  i_rst_n        in   1          async reset, active low
//  i_rx_rdy       in   1          RX FIFO non-empty
//  i_rx_data      in   8          RX FIFO head byte, valid while i_rx_rdy=1 (show-ahead)
//  o_rx_req       out  1          RX FIFO pop, 1-cycle pulse
//  i_tx_rdy       in   1          TX FIFO not full
//  o_tx_data      out  8          byte to send, valid in o_tx_req cycle
//  o_tx_req       out  1          TX FIFO push, 1-cycle pulse
//  o_mem_req      out  1          memory request, held until i_mem_ack
//  o_mem_we       out  1          1 write, 0 read; stable while o_mem_req=1
//  o_mem_addr     out  AddrWidth  word address; stable while o_mem_req=1
//  o_mem_wdata    out  DataWidth  write data; stable while o_mem_req=1
//  i_mem_ack      in   1          1-cycle completion; read data valid in same cycle
//  i_mem_rdata    in   DataWidth  read data
//  o_busy         out  1          1 in any state except IDLE
//  o_err          out  1          1-cycle pulse on bad opcode or inter-byte timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift regs and counters 0. Reset mid-packet or
//   mid-request abandons it; o_mem_req drops asynchronously.
//  Packet: 'W'(0x57) addr[AddrBytes] data[DataBytes]; 'R'(0x52) addr[AddrBytes]. All
//   fields MSB byte first; addr upper bits beyond AddrWidth discarded.
//  Response: write -> 'K'(0x4B); read -> DataBytes bytes of rdata MSB first;
//   bad opcode -> '?'(0x3F).
//  Pop rule: o_rx_req only when i_rx_rdy=1 in a receive state; byte captured from
//   i_rx_data in the pop cycle; min 1 idle cycle between pops. Push rule identical
//   on i_tx_rdy/o_tx_req. Never pop and push in the same cycle.
//  States:
//   IDLE     pop opcode; 'W'/'R' -> ADDR (latch we); other -> SEND('?'), o_err pulse.
//   ADDR     shift in AddrBytes bytes; then W -> DATA, R -> MEM.
//   DATA     shift in DataBytes bytes; then -> MEM.
//   MEM      o_mem_req=1 from entry cycle; on i_mem_ack: drop req same edge, latch
//             rdata into response shifter -> SEND. No timeout in MEM.
//   SEND     push response bytes, stalling while i_tx_rdy=0; after last push -> IDLE.
//  Timeout: counter clears on each pop, counts in ADDR/DATA; reaching TimeoutCycles
//   -> IDLE, o_err pulse, partial packet discarded, no response byte.
//  Byte counter width = clog2(max(AddrBytes,DataBytes)+1); counts down to 0.
//  Latency: last command byte popped -> o_mem_req high on next cycle.
//  i_mem_ack outside MEM is ignored.
// TESTING
//  T1 RX 57 00 01 23 BE EF -> one req we=1 addr=0x000123 wdata=0xBEEF; TX 4B.
//  T2 RX 52 00 01 23, ack after 7 cycles rdata=0xBEEF -> req we=0 addr=0x000123
//     held 7 cycles; TX BE EF; o_busy low after last push.
//  T3 RX 41 -> no mem req, o_err 1 cycle, TX 3F; then T1 packet completes normally.
//  T4 RX 57 00 01, stall > TimeoutCycles (param 100) -> o_err, IDLE, no TX;
//     next packet R 00 00 05 parsed from fresh opcode.
//  T5 T2 with i_tx_rdy=0 for 20 cycles after ack -> no push while low, TX BE EF.
//  T6 assert i_rst_n=0 during MEM -> o_mem_req 0 immediately, o_busy 0; stray
//     i_mem_ack after release ignored, no TX.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Host-debug command sequencer. Pops command packets from the uart RX FIFO,
//   issues one single-word read or write on the memory request port, and pushes
//   the response into the uart TX FIFO.
//
//   Packets (all fields MSB byte first):
//     'W' (0x57) addr[AddrBytes] data[DataBytes]  -> response 'K' (0x4B)
//     'R' (0x52) addr[AddrBytes]                  -> response rdata[DataBytes]
//     any other opcode                            -> response '?' (0x3F), o_err pulse
//
//   Ports
//     i_clk, i_rst_n            system clock, async active-low reset
//     i_rx_rdy, i_rx_data       RX FIFO non-empty / show-ahead head byte
//     o_rx_req                  RX FIFO pop pulse
//     i_tx_rdy                  TX FIFO not full
//     o_tx_data, o_tx_req       TX byte and push pulse
//     o_mem_req/we/addr/wdata   memory request, held until i_mem_ack
//     i_mem_ack, i_mem_rdata    completion pulse with read data
//     o_busy                    high in every state except IDLE
//     o_err                     pulse on bad opcode or inter-byte timeout
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for / decoding the opcode byte
//   ADDR  | shifting in the address bytes
//   DATA  | shifting in the write-data bytes
//   MEM   | memory request outstanding, waiting for i_mem_ack
//   SEND  | pushing response bytes into the TX FIFO
module uart_cmd_ctrl #(
  parameter int AddrWidth     = 24,
  parameter int DataWidth     = 16,
  parameter int TimeoutCycles = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_rdy,
  input  logic [7:0]           i_rx_data,
  output logic                 o_rx_req,
  input  logic                 i_tx_rdy,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_req,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [AddrWidth-1:0] o_mem_addr,
  output logic [DataWidth-1:0] o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [DataWidth-1:0] i_mem_rdata,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int AddrBytes = (AddrWidth + 7) / 8;
  localparam int DataBytes = DataWidth / 8;
  localparam int MaxBytes  = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
  localparam int CntW      = $clog2(MaxBytes + 1);
  localparam int TmoW      = $clog2(TimeoutCycles + 1);
  localparam int AddrShW   = AddrBytes * 8;

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RspOk   = 8'h4B;
  localparam logic [7:0] RspBad  = 8'h3F;

  localparam logic [CntW-1:0] AddrCnt = CntW'(AddrBytes);
  localparam logic [CntW-1:0] DataCnt = CntW'(DataBytes);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_SEND
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_req_q, rx_req_d;
  logic                 tx_req_q, tx_req_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 mem_req_q, mem_req_d;
  logic                 we_q, we_d;
  logic [AddrShW-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] resp_q, resp_d;
  logic [CntW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 rx_state;

  // Pops and pushes are registered: the request is decided one cycle ahead
  // and the byte is taken from i_rx_data in the cycle o_rx_req is high. The
  // "!rx_req_q" / "!tx_req_q" terms give the mandatory idle cycle between
  // consecutive pops or pushes.
  always_comb begin
    state_d    = state_q;
    tx_req_d   = 1'b0;
    tx_data_d  = tx_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    byte_cnt_d = byte_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_req_q) begin
          if (i_rx_data == OpWrite || i_rx_data == OpRead) begin
            we_d       = (i_rx_data == OpWrite);
            byte_cnt_d = AddrCnt;
            tmo_cnt_d  = TmoLoad;
            state_d    = ST_ADDR;
          end else begin
            resp_d                 = '0;
            resp_d[DataWidth-1 -: 8] = RspBad;
            tx_cnt_d               = CntOne;
            err_d                  = 1'b1;
            state_d                = ST_SEND;
          end
        end
      end

      ST_ADDR: begin
        if (rx_req_q) begin
          addr_d     = (addr_q << 8) | AddrShW'(i_rx_data);
          byte_cnt_d = byte_cnt_q - CntOne;
          tmo_cnt_d  = TmoLoad;
          if (byte_cnt_q == CntOne) begin
            if (we_q) begin
              byte_cnt_d = DataCnt;
              state_d    = ST_DATA;
            end else begin
              state_d = ST_MEM;
            end
          end
        end else if (tmo_cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TmoW'(1);
        end
      end

      ST_DATA: begin
        if (rx_req_q) begin
          wdata_d    = (wdata_q << 8) | DataWidth'(i_rx_data);
          byte_cnt_d = byte_cnt_q - CntOne;
          tmo_cnt_d  = TmoLoad;
          if (byte_cnt_q == CntOne) begin
            state_d = ST_MEM;
          end
        end else if (tmo_cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TmoW'(1);
        end
      end

      ST_MEM: begin
        if (i_mem_ack) begin
          if (we_q) begin
            resp_d                 = '0;
            resp_d[DataWidth-1 -: 8] = RspOk;
            tx_cnt_d               = CntOne;
          end else begin
            resp_d   = i_mem_rdata;
            tx_cnt_d = DataCnt;
          end
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        // Leave only after the final push cycle so o_busy covers it.
        if (tx_req_q && tx_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else if (!tx_req_q && i_tx_rdy && tx_cnt_q != '0) begin
          tx_req_d  = 1'b1;
          tx_data_d = resp_q[DataWidth-1 -: 8];
          resp_d    = resp_q << 8;
          tx_cnt_d  = tx_cnt_q - CntOne;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_state  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  // No pop is launched in a cycle that abandons the packet, so a late byte
  // is never mistaken for a fresh opcode.
  assign rx_req_d  = rx_state && i_rx_rdy && !rx_req_q && !err_d;
  assign mem_req_d = (state_d == ST_MEM);
  assign busy_d    = (state_d != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rx_req_q   <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      mem_req_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      byte_cnt_q <= '0;
      tx_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_req_q   <= rx_req_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      mem_req_q  <= mem_req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      byte_cnt_q <= byte_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_rx_req    = rx_req_q;
  assign o_tx_req    = tx_req_q;
  assign o_tx_data   = tx_data_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q[AddrWidth-1:0];
  assign o_mem_wdata = wdata_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
//   Bench for uart_cmd_ctrl: RX/TX FIFO and memory models driven on the falling
//   edge, a directed vector table, hand sequences for timeout / TX stall /
//   reset-in-MEM, and a randomized packet stream against a packet-level model.
module tb_uart_cmd_ctrl;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 100;
  localparam int NV  = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rx_rdy, i_tx_rdy, i_mem_ack;
  logic [7:0]    i_rx_data;
  logic [DW-1:0] i_mem_rdata;
  logic          o_rx_req, o_tx_req, o_mem_req, o_mem_we, o_busy, o_err;
  logic [7:0]    o_tx_data;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_rdy(i_rx_rdy), .i_rx_data(i_rx_data), .o_rx_req(o_rx_req),
    .i_tx_rdy(i_tx_rdy), .o_tx_data(o_tx_data), .o_tx_req(o_tx_req),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // ---------------- environment: FIFOs and memory ----------------
  logic [7:0]  rxq[$];
  logic [7:0]  tx_got[$];
  req_t        got_reqs[$];
  logic [15:0] mem[int];
  req_t        cur_req;
  int  cyc = 0, err_cnt = 0, req_cyc = 0, mem_lat = 2, tx_mode = 0;
  int  last_pop_cyc = 0, first_req_cyc = 0, held_last = 0;
  bit  lat_rand = 0, stray_ack = 0, ack_model = 0;
  bit  rx_pop_pending = 0, rx_rdy_prev = 0, tx_rdy_prev = 0, rx_req_prev = 0, tx_req_prev = 0;

  // Unwritten words read back as a fixed function of the address.
  function automatic logic [15:0] mem_rd(logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rx_pop_pending) begin
      if (rxq.size() > 0) void'(rxq.pop_front());
      rx_pop_pending = 0;
    end
    if (o_rx_req) begin
      chk("pop_when_rdy", rx_rdy_prev, 1);
      chk("pop_gap", rx_req_prev, 0);
      chk("pop_push_excl", o_tx_req, 0);
      last_pop_cyc   = cyc;
      rx_pop_pending = 1;
    end
    rx_req_prev = o_rx_req;
    if (o_tx_req) begin
      chk("push_when_rdy", tx_rdy_prev, 1);
      chk("push_gap", tx_req_prev, 0);
      tx_got.push_back(o_tx_data);
    end
    tx_req_prev = o_tx_req;
    if (o_err) err_cnt++;
    ack_model = 0;
    if (o_mem_req) begin
      if (req_cyc == 0) begin
        cur_req = '{we: o_mem_we, addr: o_mem_addr, wdata: o_mem_wdata};
        got_reqs.push_back(cur_req);
        first_req_cyc = cyc;
        if (lat_rand) mem_lat = $urandom_range(6, 1);
      end else begin
        chk("req_stable", {o_mem_we, o_mem_addr, o_mem_wdata}, cur_req);
      end
      req_cyc++;
      held_last = req_cyc;
      if (req_cyc == mem_lat) begin
        ack_model = 1;
        if (cur_req.we) begin
          mem[int'(cur_req.addr)] = cur_req.wdata;
          i_mem_rdata = 16'hDEAD;
        end else begin
          i_mem_rdata = mem_rd(cur_req.addr);
        end
      end
    end else begin
      req_cyc = 0;
    end
    i_mem_ack   = ack_model | stray_ack;
    i_rx_rdy    = (rxq.size() != 0);
    i_rx_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    rx_rdy_prev = i_rx_rdy;
    case (tx_mode)
      0:       i_tx_rdy = 1'b1;
      1:       i_tx_rdy = ($urandom_range(3) != 0);
      default: i_tx_rdy = 1'b0;
    endcase
    tx_rdy_prev = i_tx_rdy;
  end

  task automatic wait_idle(input int exp_tx, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (tx_got.size() >= exp_tx && !o_busy && rxq.size() == 0 && !rx_pop_pending) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic push_bytes(input logic [55:0] b, input int n);
    for (int k = 0; k < n; k++) rxq.push_back(b[55-8*k -: 8]);
  endtask

  task automatic clear_obs();
    tx_got.delete();
    got_reqs.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    int            n;
    logic [55:0]   bytes;
    int            lat;
    logic          exp_req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ntx;
    logic [15:0]   tx;
    int            nerr;
  } vec_t;

  vec_t vecs[NV];

  // Random-phase reference: expected packets computed from the packet rules.
  req_t        exp_reqs[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] ref_mem[int];

  initial begin
    vec_t        tv;
    bit          ok;
    int          e0, target;
    logic [7:0]  op;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rv;
    int          exp_err, sel;

    vecs[0] = '{n: 6, bytes: {8'h57, 8'h00, 8'h01, 8'h23, 8'hBE, 8'hEF, 8'h00}, lat: 3,
                exp_req: 1'b1, we: 1'b1, addr: 24'h000123, wdata: 16'hBEEF, ntx: 1, tx: 16'h4B00, nerr: 0};
    vecs[1] = '{n: 4, bytes: {8'h52, 8'h00, 8'h01, 8'h23, 24'h0}, lat: 7,
                exp_req: 1'b1, we: 1'b0, addr: 24'h000123, wdata: 16'h0, ntx: 2, tx: 16'hBEEF, nerr: 0};
    vecs[2] = '{n: 1, bytes: {8'h41, 48'h0}, lat: 2,
                exp_req: 1'b0, we: 1'b0, addr: 24'h0, wdata: 16'h0, ntx: 1, tx: 16'h3F00, nerr: 1};
    vecs[3] = '{n: 6, bytes: {8'h57, 8'h00, 8'h01, 8'h23, 8'hBE, 8'hEF, 8'h00}, lat: 1,
                exp_req: 1'b1, we: 1'b1, addr: 24'h000123, wdata: 16'hBEEF, ntx: 1, tx: 16'h4B00, nerr: 0};
    vecs[4] = '{n: 4, bytes: {8'h52, 8'hFF, 8'hFF, 8'hFF, 24'h0}, lat: 2,
                exp_req: 1'b1, we: 1'b0, addr: 24'hFFFFFF, wdata: 16'h0, ntx: 2, tx: 16'h5A5A, nerr: 0};
    vecs[5] = '{n: 6, bytes: {8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, lat: 4,
                exp_req: 1'b1, we: 1'b1, addr: 24'h000000, wdata: 16'h0000, ntx: 1, tx: 16'h4B00, nerr: 0};
    vecs[6] = '{n: 4, bytes: {8'h52, 8'h00, 8'h00, 8'h00, 24'h0}, lat: 2,
                exp_req: 1'b1, we: 1'b0, addr: 24'h000000, wdata: 16'h0, ntx: 2, tx: 16'h0000, nerr: 0};

    rst_n = 1'b0; i_rx_rdy = 1'b0; i_rx_data = 8'h00; i_tx_rdy = 1'b1;
    i_mem_ack = 1'b0; i_mem_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rx_req", o_rx_req, 0);
    chk("rst_tx_req", o_tx_req, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_tx_data", o_tx_data, 0);
    #1 rst_n = 1'b1;

    // Table-driven packets
    for (int v = 0; v < NV; v++) begin
      tv = vecs[v];
      @(posedge clk); #2;
      clear_obs();
      e0      = err_cnt;
      mem_lat = tv.lat;
      push_bytes(tv.bytes, tv.n);
      wait_idle(tv.ntx, 400, ok);
      repeat (3) @(posedge clk);
      #2;
      chk($sformatf("v%0d_done", v), ok, 1);
      chk($sformatf("v%0d_nreq", v), got_reqs.size(), tv.exp_req ? 1 : 0);
      if (tv.exp_req && got_reqs.size() == 1) begin
        chk($sformatf("v%0d_we", v), got_reqs[0].we, tv.we);
        chk($sformatf("v%0d_addr", v), got_reqs[0].addr, tv.addr);
        if (tv.we) chk($sformatf("v%0d_wdata", v), got_reqs[0].wdata, tv.wdata);
        chk($sformatf("v%0d_held", v), held_last, tv.lat);
        chk($sformatf("v%0d_req_latency", v), first_req_cyc - last_pop_cyc, 1);
      end
      chk($sformatf("v%0d_ntx", v), tx_got.size(), tv.ntx);
      for (int k = 0; k < tv.ntx && k < tx_got.size(); k++)
        chk($sformatf("v%0d_tx%0d", v, k), tx_got[k], tv.tx[15-8*k -: 8]);
      chk($sformatf("v%0d_err", v), err_cnt - e0, tv.nerr);
      chk($sformatf("v%0d_busy", v), o_busy, 0);
    end

    // Inter-byte timeout, then a fresh packet
    clear_obs();
    e0 = err_cnt;
    mem_lat = 2;
    push_bytes({8'h57, 8'h00, 8'h01, 32'h0}, 3);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (rxq.size() == 0 && !rx_pop_pending) begin ok = 1; break; end
    end
    chk("tmo_bytes_taken", ok, 1);
    target = last_pop_cyc + TMO - 3;
    while (cyc < target) begin @(posedge clk); #2; end
    chk("tmo_busy_before", o_busy, 1);
    chk("tmo_err_before", err_cnt - e0, 0);
    target = last_pop_cyc + TMO + 4;
    while (cyc < target) begin @(posedge clk); #2; end
    chk("tmo_busy_after", o_busy, 0);
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_no_tx", tx_got.size(), 0);
    chk("tmo_no_req", got_reqs.size(), 0);
    push_bytes({8'h52, 8'h00, 8'h00, 8'h05, 24'h0}, 4);
    wait_idle(2, 300, ok);
    chk("tmo_next_done", ok, 1);
    chk("tmo_next_nreq", got_reqs.size(), 1);
    if (got_reqs.size() == 1) begin
      chk("tmo_next_we", got_reqs[0].we, 0);
      chk("tmo_next_addr", got_reqs[0].addr, 24'h000005);
    end
    chk("tmo_next_ntx", tx_got.size(), 2);
    if (tx_got.size() == 2) chk("tmo_next_tx", {tx_got[0], tx_got[1]}, 16'hA5A0);
    chk("tmo_next_err", err_cnt - e0, 1);

    // TX FIFO full for 20 cycles after the ack
    @(posedge clk); #2;
    clear_obs();
    mem_lat = 7;
    tx_mode = 2;
    push_bytes({8'h52, 8'h00, 8'h01, 8'h23, 24'h0}, 4);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (got_reqs.size() == 1 && !o_mem_req) begin ok = 1; break; end
    end
    chk("stall_ack_seen", ok, 1);
    repeat (20) @(posedge clk);
    #2;
    chk("stall_no_push", tx_got.size(), 0);
    chk("stall_busy", o_busy, 1);
    tx_mode = 0;
    wait_idle(2, 100, ok);
    chk("stall_done", ok, 1);
    chk("stall_ntx", tx_got.size(), 2);
    if (tx_got.size() == 2) chk("stall_tx", {tx_got[0], tx_got[1]}, 16'hBEEF);

    // Reset while the memory request is outstanding
    @(posedge clk); #2;
    clear_obs();
    e0 = err_cnt;
    mem_lat = 1000;
    push_bytes({8'h52, 8'h00, 8'h00, 8'h07, 24'h0}, 4);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (o_mem_req) begin ok = 1; break; end
    end
    chk("rstmem_req_seen", ok, 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmem_req_drop", o_mem_req, 0);
    chk("rstmem_busy", o_busy, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    mem_lat = 2;
    stray_ack = 1;
    repeat (3) @(posedge clk);
    #2 stray_ack = 0;
    repeat (10) @(posedge clk);
    #2;
    chk("rstmem_no_tx", tx_got.size(), 0);
    chk("rstmem_nreq", got_reqs.size(), 1);
    chk("rstmem_busy_after", o_busy, 0);
    chk("rstmem_err", err_cnt - e0, 0);

    // Randomized packet stream against the packet-level model
    clear_obs();
    mem.delete();
    ref_mem.delete();
    exp_reqs.delete();
    exp_tx.delete();
    e0 = err_cnt;
    exp_err = 0;
    lat_rand = 1;
    tx_mode = 1;
    for (int p = 0; p < 40; p++) begin
      sel = $urandom_range(9);
      a = ($urandom_range(1) == 0) ? AW'($urandom_range(15)) : AW'($urandom);
      d = DW'($urandom);
      if (sel == 0) begin
        do op = 8'($urandom_range(255)); while (op == 8'h57 || op == 8'h52);
        rxq.push_back(op);
        exp_tx.push_back(8'h3F);
        exp_err++;
      end else if (sel[0]) begin
        push_bytes({8'h57, a, d, 8'h00}, 6);
        exp_reqs.push_back('{we: 1'b1, addr: a, wdata: d});
        ref_mem[int'(a)] = d;
        exp_tx.push_back(8'h4B);
      end else begin
        push_bytes({8'h52, a, 24'h0}, 4);
        rv = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (a[15:0] ^ 16'hA5A5);
        exp_reqs.push_back('{we: 1'b0, addr: a, wdata: 16'h0});
        exp_tx.push_back(rv[15:8]);
        exp_tx.push_back(rv[7:0]);
      end
    end
    wait_idle(exp_tx.size(), 8000, ok);
    repeat (3) @(posedge clk);
    #2;
    chk("rnd_done", ok, 1);
    chk("rnd_nreq", got_reqs.size(), exp_reqs.size());
    chk("rnd_ntx", tx_got.size(), exp_tx.size());
    chk("rnd_err", err_cnt - e0, exp_err);
    for (int i = 0; i < exp_reqs.size() && i < got_reqs.size(); i++) begin
      chk($sformatf("rnd_req%0d_we", i), got_reqs[i].we, exp_reqs[i].we);
      chk($sformatf("rnd_req%0d_addr", i), got_reqs[i].addr, exp_reqs[i].addr);
      if (exp_reqs[i].we) chk($sformatf("rnd_req%0d_wdata", i), got_reqs[i].wdata, exp_reqs[i].wdata);
    end
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
      chk($sformatf("rnd_tx%0d", i), tx_got[i], exp_tx[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
